// File: rtl/addr_sequencer.sv
// Burst/strided address generator: accepts one command, then emits one address per
// beat over a valid/ready handshake, with an optional power-of-2 wrap window.
module addr_sequencer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int LEN_WIDTH    = 16,
    parameter int STRIDE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [STRIDE_WIDTH-1:0] cmd_stride,
    input  logic                    cmd_wrap_en,
    input  logic [ADDR_WIDTH-1:0]   cmd_wrap_mask,
    output logic                    addr_valid,
    input  logic                    addr_ready,
    output logic [ADDR_WIDTH-1:0]   addr_out,
    output logic                    addr_last,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic [STRIDE_WIDTH-1:0] stride_q, stride_d;
    logic                    wrap_en_q, wrap_en_d;
    logic [ADDR_WIDTH-1:0]   mask_q, mask_d;
    logic                    done_q, done_d;

    logic [ADDR_WIDTH-1:0]   sum;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    accept;
    logic                    beat;
    logic                    last_beat;

    // Plain increment wraps modulo 2^ADDR_WIDTH; with a window only the masked offset moves.
    assign sum       = addr_q + ADDR_WIDTH'(stride_q);
    assign next_addr = wrap_en_q ? ((addr_q & ~mask_q) | (sum & mask_q)) : sum;

    assign cmd_ready  = (state_q == IDLE);
    assign addr_valid = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign addr_out   = addr_q;
    assign addr_last  = (state_q == RUN) && (remaining_q == LEN_WIDTH'(1));
    assign done       = done_q;

    assign accept    = cmd_valid && cmd_ready;
    assign beat      = addr_valid && addr_ready;
    assign last_beat = beat && addr_last;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        stride_d    = stride_q;
        wrap_en_d   = wrap_en_q;
        mask_d      = mask_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d      = cmd_addr;
                    remaining_d = cmd_len;
                    stride_d    = cmd_stride;
                    wrap_en_d   = cmd_wrap_en;
                    mask_d      = cmd_wrap_mask;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (beat) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (last_beat) begin
                        // Final address is left on addr_out; addr_valid drops with the state.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = next_addr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            stride_q    <= '0;
            wrap_en_q   <= 1'b0;
            mask_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            stride_q    <= stride_d;
            wrap_en_q   <= wrap_en_d;
            mask_q      <= mask_d;
            done_q      <= done_d;
        end
    end

endmodule
